// File: rtl/ps2_host_tx_if.sv
// Host-side command interface for the PS/2 host transmitter.
// The master issues a byte with a one-cycle txStart; the slave reports progress and completion.
interface ps2_host_tx_if;
    logic [7:0] txData;
    logic       txStart;
    logic       busy;
    logic       txDone;
    logic       txError;

    modport master (
        output txData,
        output txStart,
        input  busy,
        input  txDone,
        input  txError
    );

    modport slave (
        input  txData,
        input  txStart,
        output busy,
        output txDone,
        output txError
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues the start bit, shifts the byte, parity and stop bit on the
// device-generated clock, then checks the device ACK. Timeout and ACK failures end the
// transfer with txError. Both PS/2 lines are open-drain: this block only ever pulls low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         psClk,
    input  logic         psData,
    output logic         psClkDriveLow,
    output logic         psDataDriveLow,
    ps2_host_tx_if.slave host
);
    localparam int MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE
    } state_t;

    state_t           state;
    logic             ps_clk_p0, ps_clk_p1, ps_clk_p2;
    logic             ps_data_p0, ps_data_p1;
    logic [CNT_W-1:0] cyc_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       tx_byte;
    logic             tx_parity;
    logic             clk_fall;
    logic             timed_out;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // _p1 is the synchronized line; _p2 delays the clock one more cycle for edge detection
    assign clk_fall  = ps_clk_p2 & ~ps_clk_p1;
    // cyc_cnt is restarted on clock release, so it doubles as the transfer timeout
    assign timed_out = (cyc_cnt == TIMEOUT_LAST);

    // Synchronize the raw PS/2 lines; idle-high lines reset to 1 so no false edge appears
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ps_clk_p0  <= 1'b1;
            ps_clk_p1  <= 1'b1;
            ps_clk_p2  <= 1'b1;
            ps_data_p0 <= 1'b1;
            ps_data_p1 <= 1'b1;
        end else begin
            ps_clk_p0  <= psClk;
            ps_clk_p1  <= ps_clk_p0;
            ps_clk_p2  <= ps_clk_p1;
            ps_data_p0 <= psData;
            ps_data_p1 <= ps_data_p0;
        end
    end

    // Transfer FSM; all line drives and status outputs are registered here
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= IDLE;
            psClkDriveLow  <= 1'b0;
            psDataDriveLow <= 1'b0;
            host.busy      <= 1'b0;
            host.txDone    <= 1'b0;
            host.txError   <= 1'b0;
            cyc_cnt        <= '0;
            edge_cnt       <= '0;
            tx_byte        <= '0;
            tx_parity      <= 1'b0;
        end else begin
            host.txDone <= 1'b0;
            case (state)
                IDLE: begin
                    psClkDriveLow  <= 1'b0;
                    psDataDriveLow <= 1'b0;
                    if (host.txStart) begin
                        tx_byte       <= host.txData;
                        tx_parity     <= odd_parity(host.txData);
                        host.txError  <= 1'b0;
                        host.busy     <= 1'b1;
                        psClkDriveLow <= 1'b1;
                        cyc_cnt       <= '0;
                        state         <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cyc_cnt == INHIBIT_LAST) begin
                        cyc_cnt        <= '0;
                        psDataDriveLow <= 1'b1;
                        state          <= START;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                START: begin
                    if (cyc_cnt == START_LAST) begin
                        cyc_cnt       <= '0;
                        edge_cnt      <= '0;
                        psClkDriveLow <= 1'b0;
                        state         <= SHIFT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                SHIFT, ACK, WAIT_IDLE: begin
                    if (timed_out) begin
                        psClkDriveLow  <= 1'b0;
                        psDataDriveLow <= 1'b0;
                        host.txError   <= 1'b1;
                        host.txDone    <= 1'b1;
                        host.busy      <= 1'b0;
                        state          <= DONE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                        if (state == SHIFT && clk_fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            if (edge_cnt < 4'd8) begin
                                psDataDriveLow <= ~tx_byte[edge_cnt[2:0]];
                            end else if (edge_cnt == 4'd8) begin
                                psDataDriveLow <= ~tx_parity;
                            end else begin
                                psDataDriveLow <= 1'b0;
                                state          <= ACK;
                            end
                        end else if (state == ACK && clk_fall) begin
                            host.txError   <= ps_data_p1;
                            psDataDriveLow <= 1'b0;
                            state          <= WAIT_IDLE;
                        end else if (state == WAIT_IDLE && ps_clk_p1 && ps_data_p1) begin
                            host.txDone <= 1'b1;
                            host.busy   <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out of the host,
// the stimulus queues the expected outcome of each transfer, and a monitor checks it
// whenever the host pulses txDone.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INHIBIT = 20;
    localparam int START   = 5;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic psClkDriveLow, psDataDriveLow;
    logic ps_clk_line, ps_data_line;

    assign ps_clk_line  = dev_clk  & ~psClkDriveLow;
    assign ps_data_line = dev_data & ~psDataDriveLow;

    ps2_host_tx_if ifc();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .START_CYCLES  (START),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .psClk         (ps_clk_line),
        .psData        (ps_data_line),
        .psClkDriveLow (psClkDriveLow),
        .psDataDriveLow(psDataDriveLow),
        .host          (ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        err;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;
    exp_t sb_q[$];

    // Device model: after the host releases the clock, sample start bit, then generate
    // dev_edges falling edges, sampling the data line on each rising edge; optional ACK.
    int          dev_edges   = 11;
    bit          dev_ack     = 1'b1;
    bit          dev_busy    = 1'b0;
    int          dev_edge_no = 0;
    logic [10:0] dev_frame   = '0;

    initial begin
        forever begin
            @(negedge psClkDriveLow);
            if (ifc.busy !== 1'b1) continue;
            dev_busy    = 1'b1;
            dev_edge_no = 0;
            dev_frame   = '0;
            repeat (HALF) @(negedge clk);
            dev_frame[0] = ps_data_line;
            for (int e = 1; e <= dev_edges; e++) begin
                if (e == 11 && dev_ack) dev_data = 1'b0;
                dev_clk     = 1'b0;
                dev_edge_no = e;
                repeat (HALF) @(negedge clk);
                dev_clk = 1'b1;
                if (e <= 10) dev_frame[e] = ps_data_line;
                repeat (HALF) @(negedge clk);
                dev_data = 1'b1;
            end
            dev_busy = 1'b0;
        end
    end

    // Monitor: timing capture and scoreboard pop on txDone
    int   t_clk_rise = 0, t_clk_fall = 0, t_data_rise = 0, t_done = 0;
    logic prev_cdl = 1'b0, prev_ddl = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (psClkDriveLow === 1'b1 && prev_cdl !== 1'b1) t_clk_rise = cyc;
            if (psClkDriveLow === 1'b0 && prev_cdl === 1'b1) t_clk_fall = cyc;
            if (psDataDriveLow === 1'b1 && prev_ddl !== 1'b1 && psClkDriveLow === 1'b1)
                t_data_rise = cyc;
            if (ifc.txDone === 1'b1) begin
                t_done = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_txDone", ifc.txDone, 0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_txError"}, ifc.txError, e.err);
                    check({e.name, "_busy_low_at_done"}, ifc.busy, 0);
                    check({e.name, "_lines_released"}, {psClkDriveLow, psDataDriveLow}, 0);
                    if (e.chk_frame) check({e.name, "_frame"}, dev_frame, e.frame);
                end
            end
            prev_cdl = psClkDriveLow;
            prev_ddl = psDataDriveLow;
        end
    end

    task automatic send(input logic [7:0] d, input int edges, input bit ack, input logic err,
                        input bit chkf, input logic [10:0] fr, input bit push, input string nm);
        dev_edges = edges;
        dev_ack   = ack;
        if (push) sb_q.push_back('{name: nm, err: err, chk_frame: chkf, frame: fr});
        ifc.txData  = d;
        ifc.txStart = 1'b1;
        @(negedge clk);
        ifc.txStart = 1'b0;
        check({nm, "_busy_on_accept"}, ifc.busy, 1);
        check({nm, "_txError_cleared"}, ifc.txError, 0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (ifc.busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({nm, "_done_bound"}, ifc.busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_dev(input string nm, input int budget);
        int n = 0;
        while (dev_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({nm, "_device_idle_bound"}, dev_busy, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_edge(input string nm, input int edge_no, input int budget);
        int n = 0;
        while (dev_edge_no != edge_no && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({nm, "_edge_bound"}, dev_edge_no, edge_no);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.txData  = 8'h00;
        ifc.txStart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk_drive", psClkDriveLow, 0);
        check("rst_data_drive", psDataDriveLow, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_txDone", ifc.txDone, 0);
        check("rst_txError", ifc.txError, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED with ACK; a second start mid-transfer must be ignored
        send(8'hED, 11, 1'b1, 1'b0, 1'b1, 11'b1_1_11101101_0, 1'b1, "ed");
        wait_edge("ed", 3, 1000);
        ifc.txData  = 8'h00;
        ifc.txStart = 1'b1;
        @(negedge clk);
        ifc.txStart = 1'b0;
        wait_done("ed", 2000);
        check("ed_clk_low_cycles", t_clk_fall - t_clk_rise, INHIBIT + START);
        check("ed_data_rise_delay", t_data_rise - t_clk_rise, INHIBIT);
        wait_dev("ed", 1000);
        check("ed_no_second_transfer", ifc.busy, 0);

        send(8'h01, 11, 1'b1, 1'b0, 1'b1, 11'b1_0_00000001_0, 1'b1, "x01");
        wait_done("x01", 2000);
        wait_dev("x01", 1000);

        send(8'hFF, 11, 1'b1, 1'b0, 1'b1, 11'b1_1_11111111_0, 1'b1, "xff");
        wait_done("xff", 2000);
        wait_dev("xff", 1000);

        // Device never ACKs
        send(8'h3C, 11, 1'b0, 1'b1, 1'b1, 11'b1_1_00111100_0, 1'b1, "noack");
        wait_done("noack", 2000);
        wait_dev("noack", 1000);

        // Device stops after 4 edges: host times out
        send(8'h00, 4, 1'b1, 1'b1, 1'b0, 11'd0, 1'b1, "timeout");
        wait_done("timeout", 4000);
        check("timeout_latency", t_done - t_clk_fall, TIMEOUT);
        wait_dev("timeout", 1000);

        // Reset in the middle of the shift phase
        send(8'hA5, 11, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, "midrst");
        wait_edge("midrst", 5, 1000);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_clk_drive", psClkDriveLow, 0);
        check("midrst_data_drive", psDataDriveLow, 0);
        check("midrst_busy", ifc.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_dev("midrst", 1000);
        check("midrst_idle_after", ifc.busy, 0);

        send(8'h5A, 11, 1'b1, 1'b0, 1'b1, 11'b1_1_01011010_0, 1'b1, "after_rst");
        wait_done("after_rst", 2000);
        wait_dev("after_rst", 1000);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
